// File: rtl/life_seq_ctrl_if.sv
// HPS download port bundle: run-length board bytes in, stall back out.
interface life_seq_ctrl_if;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_dout;
  logic       ioctl_wait;

  modport master (output ioctl_download, ioctl_wr, ioctl_dout, input ioctl_wait);
  modport slave  (input ioctl_download, ioctl_wr, ioctl_dout, output ioctl_wait);
endinterface

// File: rtl/life_seq_ctrl.sv
// Frame-buffer ring and generation sequencer: RLE board upload, zero pad,
// start-of-frame alignment and generation stepping via clock enables.
module life_seq_ctrl #(
  parameter int unsigned RING_LEN = 2475000,
  parameter int unsigned POS_W    = 22
) (
  input  logic          HDMI_CLK,
  input  logic          RESET_N,
  life_seq_ctrl_if.slave ioctl,
  input  logic          sof,
  input  logic          run,
  input  logic          step_req,
  input  logic [2:0]    speed,
  output logic          ring_en,
  output logic          ring_load,
  output logic          load_bit,
  output logic          gen_en,
  output logic          evolve,
  output logic [15:0]   gen_count,
  output logic          load_trunc,
  output logic          sync_err
);

  localparam logic [POS_W-1:0] POS_END  = POS_W'(RING_LEN);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(RING_LEN - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic [1:0] {S_SYNC, S_RUN, S_LOAD, S_PAD} state_t;

  state_t           state;
  logic [POS_W-1:0] pos;
  logic [2:0]       fdiv;
  logic             step_pend;
  logic             dl_q;
  logic             busy;
  logic [6:0]       rem;
  logic             bit_val;

  logic             dl_rise;
  logic             sof_take;
  logic             evolve_c;
  logic             emit;
  logic             emit_val;
  logic [POS_W-1:0] pos_wrap;

  assign dl_rise  = ioctl.ioctl_download & ~dl_q;
  assign sof_take = sof & ~dl_rise & ((state == S_SYNC) | (state == S_RUN));
  assign evolve_c = step_pend | step_req | (run & (fdiv == speed));
  assign pos_wrap = (pos == POS_LAST) ? '0 : pos + POS_ONE;

  assign ioctl.ioctl_wait = ioctl.ioctl_wr | busy;

  // Bit to shift into the ring this coming cycle, from a byte run or padding
  always_comb begin
    emit     = 1'b0;
    emit_val = 1'b0;
    if (!dl_rise) begin
      case (state)
        S_LOAD: begin
          if (busy) begin
            emit     = (rem != 7'd0);
            emit_val = bit_val;
          end else if (ioctl.ioctl_wr && ioctl.ioctl_download) begin
            emit     = 1'b1;
            emit_val = ioctl.ioctl_dout[7];
          end
        end
        S_PAD:   emit = (pos < POS_END);
        default: emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge HDMI_CLK) begin
    if (!RESET_N) begin
      state      <= S_SYNC;
      pos        <= '0;
      fdiv       <= '0;
      step_pend  <= 1'b0;
      dl_q       <= 1'b0;
      busy       <= 1'b0;
      rem        <= '0;
      bit_val    <= 1'b0;
      ring_en    <= 1'b0;
      ring_load  <= 1'b0;
      load_bit   <= 1'b0;
      gen_en     <= 1'b0;
      evolve     <= 1'b0;
      gen_count  <= '0;
      load_trunc <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dl_q      <= ioctl.ioctl_download;
      ring_en   <= 1'b0;
      ring_load <= 1'b0;
      load_bit  <= 1'b0;
      gen_en    <= 1'b0;

      // Generation scheduling: evolve is fixed for the frame starting at sof
      if (sof_take)      step_pend <= 1'b0;
      else if (step_req) step_pend <= 1'b1;

      if (!run) fdiv <= '0;
      if (sof_take) begin
        evolve <= evolve_c;
        if (evolve_c) gen_count <= gen_count + 16'd1;
        if (run) fdiv <= (fdiv == speed) ? 3'd0 : fdiv + 3'd1;
      end

      if (dl_rise) begin
        state      <= S_LOAD;
        pos        <= '0;
        load_trunc <= 1'b0;
        busy       <= 1'b0;
        rem        <= '0;
      end else begin
        case (state)
          S_SYNC: begin
            if (sof) begin
              state   <= S_RUN;
              pos     <= POS_ONE;
              ring_en <= 1'b1;
              gen_en  <= 1'b1;
            end
          end
          S_RUN: begin
            ring_en <= 1'b1;
            gen_en  <= 1'b1;
            // sof cycle is position 0, so the following cycle is position 1
            if (sof) begin
              pos <= POS_ONE;
              if (pos != '0) sync_err <= 1'b1;
            end else begin
              pos <= pos_wrap;
            end
          end
          S_LOAD: begin
            if (busy) begin
              if (rem != 7'd0) rem  <= rem - 7'd1;
              else             busy <= 1'b0;
            end else if (ioctl.ioctl_wr && ioctl.ioctl_download) begin
              busy    <= 1'b1;
              rem     <= ioctl.ioctl_dout[6:0];
              bit_val <= ioctl.ioctl_dout[7];
            end else if (!ioctl.ioctl_download) begin
              state <= (pos >= POS_END) ? S_SYNC : S_PAD;
            end
          end
          S_PAD: begin
            if (pos >= POS_END) state <= S_SYNC;
          end
          default: state <= S_SYNC;
        endcase

        // Load/pad shift; bits past the ring end burn a cycle but are dropped
        if (emit) begin
          ring_load <= 1'b1;
          load_bit  <= emit_val;
          if (pos < POS_END) begin
            ring_en <= 1'b1;
            pos     <= pos + POS_ONE;
          end else begin
            load_trunc <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_life_seq_ctrl.sv
// Directed bench for life_seq_ctrl with a 64-bit ring and 64-cycle frames.
module tb_life_seq_ctrl;
  localparam int unsigned RING_LEN = 64;
  localparam int unsigned POS_W    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof, run, step_req;
  logic [2:0]  speed;
  logic        ring_en, ring_load, load_bit, gen_en, evolve;
  logic [15:0] gen_count;
  logic        load_trunc, sync_err;

  life_seq_ctrl_if bus ();

  life_seq_ctrl #(.RING_LEN(RING_LEN), .POS_W(POS_W)) dut (
    .HDMI_CLK   (clk),
    .RESET_N    (rst_n),
    .ioctl      (bus),
    .sof        (sof),
    .run        (run),
    .step_req   (step_req),
    .speed      (speed),
    .ring_en    (ring_en),
    .ring_load  (ring_load),
    .load_bit   (load_bit),
    .gen_en     (gen_en),
    .evolve     (evolve),
    .gen_count  (gen_count),
    .load_trunc (load_trunc),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Running totals of shift activity, sampled mid-cycle
  int n_one = 0, n_zero = 0, n_drop = 0, n_busy = 0;
  always @(negedge clk) begin
    if (ring_en && ring_load && load_bit)  n_one++;
    if (ring_en && ring_load && !load_bit) n_zero++;
    if (!ring_en && ring_load)             n_drop++;
    if (bus.ioctl_wait && !bus.ioctl_wr)   n_busy++;
  end

  int s_one, s_zero, s_drop, s_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap();
    s_one  = n_one;
    s_zero = n_zero;
    s_drop = n_drop;
    s_busy = n_busy;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && bus.ioctl_wait; i++) tick();
    check(tag, 32'(bus.ioctl_wait), 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_idle("ready");
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_dout = b;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic frame(input logic sreq);
    sof      = 1'b1;
    step_req = sreq;
    tick();
    sof      = 1'b0;
    step_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sof = 1'b0; run = 1'b0; step_req = 1'b0; speed = 3'd0;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b1; bus.ioctl_dout = 8'h00;
    idle(3);

    // Reset state: ioctl_wait follows ioctl_wr only
    check("rst_wait_wr", 32'(bus.ioctl_wait), 1);
    bus.ioctl_wr = 1'b0;
    #1;
    check("rst_wait", 32'(bus.ioctl_wait), 0);
    check("rst_outs", 32'({ring_en, ring_load, load_bit, gen_en, evolve, load_trunc, sync_err}), 0);
    check("rst_gen", 32'(gen_count), 0);
    rst_n = 1'b1;
    idle(2);

    // Exact-fit load: 32 ones, 32 zeros, no pad
    snap();
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(8'h9F);
    check("first_bit", 32'({ring_en, ring_load, load_bit}), 32'h7);
    send_byte(8'h1F);
    wait_idle("fit_done");
    bus.ioctl_download = 1'b0;
    idle(10);
    check("fit_ones",  32'(n_one - s_one), 32);
    check("fit_zeros", 32'(n_zero - s_zero), 32);
    check("fit_busy",  32'(n_busy - s_busy), 64);
    check("fit_drop",  32'(n_drop - s_drop), 0);
    check("fit_trunc", 32'(load_trunc), 0);
    check("fit_sync_idle", 32'(ring_en), 0);
    frame(1'b0);
    check("fit_run", 32'({ring_en, gen_en, ring_load, evolve}), 32'hC);

    // Short load plus pad
    idle(20);
    snap();
    bus.ioctl_download = 1'b1;
    tick();
    check("load_gen_off", 32'(gen_en), 0);
    send_byte(8'h84);
    wait_idle("short_done");
    bus.ioctl_download = 1'b0;
    idle(80);
    check("short_ones",  32'(n_one - s_one), 5);
    check("short_pad",   32'(n_zero - s_zero), 59);
    check("short_trunc", 32'(load_trunc), 0);
    check("short_idle",  32'({ring_en, gen_en}), 0);

    // Overflow: 128 bits into a 64-bit ring
    snap();
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(8'hFF);
    wait_idle("ovf_done");
    check("ovf_ones",  32'(n_one - s_one), 64);
    check("ovf_drop",  32'(n_drop - s_drop), 64);
    check("ovf_trunc", 32'(load_trunc), 1);
    bus.ioctl_download = 1'b0;
    idle(5);
    check("ovf_nopad", 32'(n_zero - s_zero), 0);

    // Empty upload clears the sticky flag and pads the whole ring
    snap();
    bus.ioctl_download = 1'b1;
    tick();
    check("trunc_clear", 32'(load_trunc), 0);
    bus.ioctl_download = 1'b0;
    idle(80);
    check("empty_pad", 32'(n_zero - s_zero), 64);

    // Divisor: speed=2 evolves on frames 3, 6, 9
    run = 1'b1;
    speed = 3'd2;
    for (int f = 1; f <= 9; f++) begin
      frame(1'b0);
      check($sformatf("div_ev%0d", f), 32'(evolve), (f % 3 == 0) ? 1 : 0);
      idle(63);
    end
    check("div_gen", 32'(gen_count), 3);
    check("div_sync", 32'(sync_err), 0);

    // Single step while paused
    run = 1'b0;
    frame(1'b0);
    check("pause_ev", 32'(evolve), 0);
    idle(30);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    idle(32);
    frame(1'b0);
    check("step_ev", 32'(evolve), 1);
    check("step_gen", 32'(gen_count), 4);
    idle(63);
    frame(1'b0);
    check("step_after", 32'(evolve), 0);
    idle(63);
    frame(1'b1);
    check("step_sof_ev", 32'(evolve), 1);
    check("step_sof_gen", 32'(gen_count), 5);
    idle(63);
    frame(1'b0);
    check("step_sof_after", 32'(evolve), 0);
    check("step_sof_gen2", 32'(gen_count), 5);
    check("aligned_sync", 32'(sync_err), 0);

    // Misaligned sof at position 40
    idle(39);
    frame(1'b0);
    check("sync_err", 32'(sync_err), 1);
    check("sync_still_run", 32'({ring_en, gen_en}), 32'h3);

    // Reset in the middle of a load
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(8'h9F);
    idle(5);
    rst_n = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    check("mid_rst_outs", 32'({ring_en, ring_load, load_bit, gen_en, evolve, load_trunc, sync_err}), 0);
    check("mid_rst_gen", 32'(gen_count), 0);
    check("mid_rst_wait", 32'(bus.ioctl_wait), 0);
    rst_n = 1'b1;
    idle(3);
    check("mid_rst_sync", 32'(ring_en), 0);
    frame(1'b0);
    check("mid_rst_run", 32'({ring_en, gen_en}), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
